// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: central stall / bubble controller for the 5-stage LC-3b
// pipeline. Combines the ID-stage load-use check with the I-cache and D-cache
// handshakes. It drives the front (PC, IF/ID) and back (ID/EX, EX/MEM, MEM/WB)
// stall lines and the ID/EX bubble insert. It also holds an I-cache response
// that returns early while the pipeline is stalled, and runs a sticky
// watchdog on memory waits.
//
// Optional build macro HAZARD_PERF_CNT_EN adds the perf_clear input and two
// free-running performance counters: perf_mem_stall and perf_bubbles.
module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 1024,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [2:0] id_sr1_reg,
    input  logic [2:0] id_sr2_reg,
    input  logic       id_uses_sr1,
    input  logic       id_uses_sr2,
    input  logic       ex_valid,
    input  logic [2:0] ex_dest,
    input  logic       ex_load_regfile,
    input  logic       ex_mem_read,
    input  logic       imem_read,
    input  logic       imem_resp,
    input  logic       dmem_req,
    input  logic       dmem_resp,
    output logic       front_stall,
    output logic       back_stall,
    output logic       id_ex_bubble,
    output logic       imem_read_mask,
    output logic       fetch_latch_en,
    output logic       err_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    input  logic             perf_clear,
    output logic [CNT_W-1:0] perf_mem_stall,
    output logic [CNT_W-1:0] perf_bubbles
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_BUBBLE   = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    // The watchdog counter only has to reach MEM_TIMEOUT, where it saturates.
    localparam int WC_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LIMIT = WC_W'(MEM_TIMEOUT);

    state_t          state_q, state_d;
    logic            imem_done_q, imem_done_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            err_q, err_d;

    logic            imem_busy;
    logic            dmem_busy;
    logic            mem_busy;
    logic            load_use;
    logic            front_stall_w;

    // Source-operand match against the ID/EX destination, one lane per source.
    logic [2:0] src_reg [2];
    logic [1:0] src_use;
    logic [1:0] src_hit;

    assign src_reg[0] = id_sr1_reg;
    assign src_reg[1] = id_sr2_reg;
    assign src_use    = {id_uses_sr2, id_uses_sr1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_use[gi] & (src_reg[gi] == ex_dest);
        end
    endgenerate

    // Memory waits. An I-cache response that is already held does not count
    // as busy, because the fetch is not re-issued.
    assign imem_busy = imem_read & ~imem_resp & ~imem_done_q;
    assign dmem_busy = dmem_req & ~dmem_resp;
    assign mem_busy  = imem_busy | dmem_busy;

    // A load in EX feeds a register that the ID instruction reads.
    assign load_use = id_valid & ex_valid & ex_mem_read & ex_load_regfile & (|src_hit);

    assign front_stall_w  = mem_busy | load_use;
    assign front_stall    = front_stall_w;
    assign back_stall     = mem_busy;
    assign id_ex_bubble   = load_use & ~mem_busy;
    assign imem_read_mask = imem_done_q;
    assign fetch_latch_en = imem_read & imem_resp & ~imem_done_q & front_stall_w;
    assign err_timeout    = err_q;

    // The early-fetch flag sets when the I-cache answers during a stall. It
    // clears on the first cycle the front end moves, and clearing wins.
    always_comb begin
        imem_done_d = imem_done_q;
        if (imem_read & imem_resp & (dmem_busy | load_use)) begin
            imem_done_d = 1'b1;
        end
        if (!front_stall_w) begin
            imem_done_d = 1'b0;
        end
    end

    // Next-state logic. A memory wait always takes priority over a load-use
    // bubble. When the wait ends, the bubble is raised combinationally in the
    // same exit cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    state_d = ST_MEM_WAIT;
                end else if (load_use) begin
                    state_d = ST_BUBBLE;
                end
            end
            ST_BUBBLE: begin
                if (mem_busy) begin
                    state_d = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_busy) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Watchdog. The count restarts on entry to MEM_WAIT, steps once per
    // MEM_WAIT cycle and saturates. The error is sticky until reset.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if ((state_q != ST_MEM_WAIT) && (state_d == ST_MEM_WAIT)) begin
            wait_cnt_d = '0;
        end else if ((state_q == ST_MEM_WAIT) && (wait_cnt_q != WC_LIMIT)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        err_d = err_q | (wait_cnt_d == WC_LIMIT);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            imem_done_q <= 1'b0;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_done_q <= imem_done_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] perf_mem_stall_q, perf_mem_stall_d;
    logic [CNT_W-1:0] perf_bubbles_q, perf_bubbles_d;

    // Counter next values. A clear overrides the increment, and both
    // counters wrap.
    always_comb begin
        perf_mem_stall_d = perf_mem_stall_q;
        perf_bubbles_d   = perf_bubbles_q;
        if (perf_clear) begin
            perf_mem_stall_d = '0;
            perf_bubbles_d   = '0;
        end else begin
            if (mem_busy) begin
                perf_mem_stall_d = perf_mem_stall_q + 1'b1;
            end
            if (load_use & ~mem_busy) begin
                perf_bubbles_d = perf_bubbles_q + 1'b1;
            end
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_mem_stall_q <= '0;
            perf_bubbles_q   <= '0;
        end else begin
            perf_mem_stall_q <= perf_mem_stall_d;
            perf_bubbles_q   <= perf_bubbles_d;
        end
    end

    assign perf_mem_stall = perf_mem_stall_q;
    assign perf_bubbles   = perf_bubbles_q;
`else
    // Counters are absent. The width parameter stays referenced so that
    // both builds share one parameter list.
    logic [CNT_W-1:0] perf_unused;
    assign perf_unused = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl. It runs a table of single-cycle vectors,
// then hand-written multi-cycle sequences: load-use, D-cache wait, early
// I-cache fetch, load-use during a wait, and the watchdog with async reset.
module tb_hazard_stall_ctrl;

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_BUBBLE   = 2'd1;
    localparam logic [1:0] S_MEM_WAIT = 2'd2;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_uses_sr1, id_uses_sr2;
    logic [2:0] id_sr1_reg, id_sr2_reg, ex_dest;
    logic       ex_valid, ex_load_regfile, ex_mem_read;
    logic       imem_read, imem_resp, dmem_req, dmem_resp;
    logic       front_stall, back_stall, id_ex_bubble;
    logic       imem_read_mask, fetch_latch_en, err_timeout;
    logic [1:0] dut_state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MEM_TIMEOUT(8), .CNT_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_sr1_reg      (id_sr1_reg),
        .id_sr2_reg      (id_sr2_reg),
        .id_uses_sr1     (id_uses_sr1),
        .id_uses_sr2     (id_uses_sr2),
        .ex_valid        (ex_valid),
        .ex_dest         (ex_dest),
        .ex_load_regfile (ex_load_regfile),
        .ex_mem_read     (ex_mem_read),
        .imem_read       (imem_read),
        .imem_resp       (imem_resp),
        .dmem_req        (dmem_req),
        .dmem_resp       (dmem_resp),
        .front_stall     (front_stall),
        .back_stall      (back_stall),
        .id_ex_bubble    (id_ex_bubble),
        .imem_read_mask  (imem_read_mask),
        .fetch_latch_en  (fetch_latch_en),
        .err_timeout     (err_timeout)
    );

    assign dut_state = dut.state_q;

    // Expected outputs are packed as {front, back, bubble, mask, latch, err}.
    typedef struct {
        logic       idv;
        logic [2:0] s1;
        logic [2:0] s2;
        logic       u1;
        logic       u2;
        logic       exv;
        logic [2:0] exd;
        logic       lr;
        logic       mr;
        logic       ir;
        logic       irs;
        logic       dq;
        logic       drs;
        logic [5:0] exp;
    } vec_t;

    logic [5:0] exp_q [$];
    string      name_q [$];
    vec_t       tbl [15];

    function automatic vec_t mk(logic idv, logic [2:0] s1, logic [2:0] s2, logic u1, logic u2,
                                logic exv, logic [2:0] exd, logic lr, logic mr,
                                logic ir, logic irs, logic dq, logic drs, logic [5:0] exp);
        vec_t v;
        v.idv = idv; v.s1 = s1; v.s2 = s2; v.u1 = u1; v.u2 = u2;
        v.exv = exv; v.exd = exd; v.lr = lr; v.mr = mr;
        v.ir = ir; v.irs = irs; v.dq = dq; v.drs = drs; v.exp = exp;
        return v;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, req);
        end
    endtask

    task automatic chk_state(input string nm, input logic [1:0] req);
        n_cmp++;
        if (dut_state !== req) begin
            n_bad++;
            $display("FAIL %s state: got %0d expected %0d", nm, dut_state, req);
        end
    endtask

    task automatic drive(input vec_t v);
        id_valid = v.idv; id_sr1_reg = v.s1; id_sr2_reg = v.s2;
        id_uses_sr1 = v.u1; id_uses_sr2 = v.u2;
        ex_valid = v.exv; ex_dest = v.exd; ex_load_regfile = v.lr; ex_mem_read = v.mr;
        imem_read = v.ir; imem_resp = v.irs; dmem_req = v.dq; dmem_resp = v.drs;
    endtask

    // Pop the oldest expectation and compare it against the live outputs.
    task automatic check_outputs();
        logic [5:0] e;
        string      nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk1({nm, " front_stall"},    front_stall,    e[5]);
        chk1({nm, " back_stall"},     back_stall,     e[4]);
        chk1({nm, " id_ex_bubble"},   id_ex_bubble,   e[3]);
        chk1({nm, " imem_read_mask"}, imem_read_mask, e[2]);
        chk1({nm, " fetch_latch_en"}, fetch_latch_en, e[1]);
        chk1({nm, " err_timeout"},    err_timeout,    e[0]);
        $display("txn %-14s out=%b%b%b%b%b%b exp=%b state=%0d", nm, front_stall, back_stall,
                 id_ex_bubble, imem_read_mask, fetch_latch_en, err_timeout, e, dut_state);
    endtask

    // Drive one cycle just after the edge and check at the falling edge.
    task automatic step(input vec_t v, input string nm);
        @(posedge clk);
        #1;
        drive(v);
        exp_q.push_back(v.exp);
        name_q.push_back(nm);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset(input string nm);
        @(posedge clk);
        #1;
        drive(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000));
        reset = 1'b1;
        exp_q.push_back(6'b000000);
        name_q.push_back(nm);
        @(negedge clk);
        check_outputs();
        chk_state(nm, S_RUN);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running at %0t, expected done", $time);
        $fatal(1, "bench timeout");
    end

    vec_t lu;     // load R3 in EX, ID reads R3 through SR1
    vec_t lu_dw;  // same hazard while the D-cache is busy

    initial begin
        reset = 1'b1;
        drive(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000));

        tbl[0]  = mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000); // idle
        tbl[1]  = mk(1,3,0,1,0, 1,3,1,1, 0,0,0,0, 6'b101000); // load-use on SR1
        tbl[2]  = mk(1,5,3,1,0, 1,3,1,1, 0,0,0,0, 6'b000000); // imm mode, sr2 ignored
        tbl[3]  = mk(1,1,6,1,1, 1,6,1,1, 0,0,0,0, 6'b101000); // load-use on SR2
        tbl[4]  = mk(1,3,0,1,0, 1,3,1,0, 0,0,0,0, 6'b000000); // ALU op in EX
        tbl[5]  = mk(1,3,0,1,0, 0,3,1,1, 0,0,0,0, 6'b000000); // EX is a bubble
        tbl[6]  = mk(0,3,0,1,0, 1,3,1,1, 0,0,0,0, 6'b000000); // ID empty
        tbl[7]  = mk(1,3,0,1,0, 1,3,0,1, 0,0,0,0, 6'b000000); // no regfile write
        tbl[8]  = mk(0,0,0,0,0, 0,0,0,0, 1,0,0,0, 6'b110000); // I-cache busy
        tbl[9]  = mk(0,0,0,0,0, 0,0,0,0, 1,1,0,0, 6'b000000); // I-cache hit, no stall
        tbl[10] = mk(0,0,0,0,0, 0,0,0,0, 0,0,1,0, 6'b110000); // D-cache busy
        tbl[11] = mk(0,0,0,0,0, 0,0,0,0, 0,0,1,1, 6'b000000); // D-cache responds
        tbl[12] = mk(1,3,0,1,0, 1,3,1,1, 0,0,1,0, 6'b110000); // load-use under wait
        tbl[13] = mk(1,3,4,0,1, 1,3,1,1, 0,0,0,0, 6'b000000); // SR1 match but unused
        tbl[14] = mk(1,1,2,1,1, 1,7,1,1, 0,0,0,0, 6'b000000); // no register match

        lu    = mk(1,3,0,1,0, 1,3,1,1, 0,0,0,0, 6'b101000);
        lu_dw = mk(1,3,0,1,0, 1,3,1,1, 0,0,1,0, 6'b110000);

        do_reset("reset");
        for (int i = 0; i < 15; i++) begin
            step(tbl[i], $sformatf("tbl%0d", i));
        end

        // A load-use bubble lasts one cycle, then EX holds the NOP.
        do_reset("rst_lu");
        step(lu, "lu_c0");
        step(mk(1,3,0,1,0, 0,3,1,1, 0,0,0,0, 6'b000000), "lu_c1");
        chk_state("lu_c1", S_BUBBLE);

        // D-cache wait with the response arriving in cycle 5.
        do_reset("rst_dw");
        for (int c = 0; c < 5; c++) begin
            step(mk(0,0,0,0,0, 0,0,0,0, 0,0,1,0, 6'b110000), $sformatf("dw_c%0d", c));
        end
        step(mk(0,0,0,0,0, 0,0,0,0, 0,0,1,1, 6'b000000), "dw_c5");
        chk_state("dw_c5", S_MEM_WAIT);
        step(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000), "dw_c6");
        chk_state("dw_c6", S_RUN);

        // The I-cache answers early in cycle 1 while the D-cache stalls.
        do_reset("rst_if");
        step(mk(0,0,0,0,0, 0,0,0,0, 1,0,1,0, 6'b110000), "if_c0");
        step(mk(0,0,0,0,0, 0,0,0,0, 1,1,1,0, 6'b110010), "if_c1");
        step(mk(0,0,0,0,0, 0,0,0,0, 1,0,1,0, 6'b110100), "if_c2");
        step(mk(0,0,0,0,0, 0,0,0,0, 1,0,1,0, 6'b110100), "if_c3");
        step(mk(0,0,0,0,0, 0,0,0,0, 1,0,1,1, 6'b000100), "if_c4");
        step(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000), "if_c5");

        // Load-use during a 3-cycle D-cache wait gives exactly one bubble.
        do_reset("rst_ld");
        for (int c = 0; c < 3; c++) begin
            step(lu_dw, $sformatf("ld_c%0d", c));
        end
        step(mk(1,3,0,1,0, 1,3,1,1, 0,0,1,1, 6'b101000), "ld_c3");
        chk_state("ld_c3", S_MEM_WAIT);
        step(mk(1,3,0,1,0, 0,3,1,1, 0,0,0,0, 6'b000000), "ld_c4");
        chk_state("ld_c4", S_RUN);

        // Watchdog with MEM_TIMEOUT=8: MEM_WAIT covers cycles 1..8, and the
        // error is visible from cycle 9 on.
        do_reset("rst_wd");
        for (int c = 0; c < 12; c++) begin
            step(mk(0,0,0,0,0, 0,0,0,0, 0,0,1,0, (c >= 9) ? 6'b110001 : 6'b110000),
                 $sformatf("wd_c%0d", c));
            if (c == 1) chk_state("wd_c1", S_MEM_WAIT);
        end
        step(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000001), "wd_c12");
        step(mk(0,0,0,0,0, 0,0,0,0, 0,0,1,0, 6'b110001), "wd_c13");
        step(mk(0,0,0,0,0, 0,0,0,0, 0,0,1,0, 6'b110001), "wd_c14");
        chk_state("wd_c14", S_MEM_WAIT);
        // Reset asserted mid-cycle takes effect without a clock edge.
        #1;
        reset = 1'b1;
        #1;
        chk1("wd_async err_timeout", err_timeout, 1'b0);
        chk_state("wd_async", S_RUN);
        $display("txn wd_async       err=%b state=%0d", err_timeout, dut_state);
        #1;
        reset = 1'b0;
        step(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000), "wd_post0");
        step(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0, 6'b000000), "wd_post1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central stall/bubble controller for the 5-stage LC-3b pipeline.
- Reads the ID-stage source registers and the ID/EX register's dest/control fields, plus the I-cache and D-cache handshakes.
- Drives the stall_pipeline inputs of every pipeline register (front and back groups) and the ID/EX bubble-insert control.
- Tracks memory-wait state, latches early I-cache responses, and runs a watchdog on memory waits.

Parameters:
- MEM_TIMEOUT, 1024, cycles in MEM_WAIT before err_timeout sets.
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_sr1_reg  in  3  ID-stage SR1 register number.
- id_sr2_reg  in  3  ID-stage SR2 register number.
- id_uses_sr1  in  1  ID instruction reads SR1.
- id_uses_sr2  in  1  ID instruction reads SR2 (0 when imm_mode).
- ex_valid  in  1  ID/EX holds a real instruction (0 for bubble).
- ex_dest  in  3  ID/EX dest_out.
- ex_load_regfile  in  1  ID/EX ctrl writes the register file.
- ex_mem_read  in  1  ID/EX ctrl is a load (LDR/LDB/LDI).
- imem_read  in  1  IF stage fetch request.
- imem_resp  in  1  I-cache response.
- dmem_req  in  1  MEM stage read or write request.
- dmem_resp  in  1  D-cache response.
- front_stall  out  1  hold PC and IF/ID.
- back_stall  out  1  hold ID/EX, EX/MEM, MEM/WB.
- id_ex_bubble  out  1  load NOP (ctrl=0, valid=0) into ID/EX.
- imem_read_mask  out  1  suppress imem_read (fetch already returned).
- fetch_latch_en  out  1  IF captures the instruction word into its holding register.
- err_timeout  out  1  sticky watchdog error.

Behaviour:
- Combinational terms:
  - imem_busy = imem_read & ~imem_resp & ~imem_done
  - dmem_busy = dmem_req & ~dmem_resp
  - mem_busy = imem_busy | dmem_busy
  - load_use = id_valid & ex_valid & ex_mem_read & ex_load_regfile & ((id_uses_sr1 & id_sr1_reg==ex_dest) | (id_uses_sr2 & id_sr2_reg==ex_dest))
- Outputs, all combinational from inputs and state, zero-latency:
  - front_stall = mem_busy | load_use
  - back_stall = mem_busy
  - id_ex_bubble = load_use & ~mem_busy
  - imem_read_mask = imem_done
  - fetch_latch_en = imem_read & imem_resp & ~imem_done & (mem_busy | load_use)
- imem_done register:
  - Set when imem_resp arrives while the pipeline remains stalled (dmem_busy or load_use). An early fetch is held and not re-issued.
  - Cleared on the first cycle where front_stall=0.
  - If set and clear coincide, clear wins.
- State machine, 2-bit, three states:
  - RUN -> MEM_WAIT if mem_busy.
  - RUN -> BUBBLE if load_use & ~mem_busy.
  - BUBBLE -> RUN unconditionally. The inserted NOP makes ex_valid=0, so the hazard clears. BUBBLE -> MEM_WAIT if mem_busy.
  - MEM_WAIT -> RUN when ~mem_busy. Exit is same-cycle: outputs follow the combinational terms, so no dead cycle after a response.
  - load_use with mem_busy: the memory wait is served first. load_use is re-evaluated after the wait, yielding exactly one bubble.
- Watchdog:
  - wait_cnt clears on entering MEM_WAIT and increments each MEM_WAIT cycle, saturating.
  - When wait_cnt reaches MEM_TIMEOUT, err_timeout sets. It clears only on reset.
- Reset values:
  - state=RUN, imem_done=0, wait_cnt=0, err_timeout=0.
  - All other outputs follow the combinational terms with imem_done=0. With all inputs 0, every output is 0.
- Reset asserted mid-stall returns to RUN immediately. Pending cache handshakes are the cache's responsibility.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds output ports perf_mem_stall (CNT_W), perf_bubbles (CNT_W) and input perf_clear (1).
  - perf_mem_stall counts cycles with back_stall=1.
  - perf_bubbles counts cycles with id_ex_bubble=1.
  - Both counters wrap modulo 2^CNT_W and clear on reset or perf_clear. perf_clear has priority over increment.
- Undefined: ports and counters absent. All other behaviour identical.

Test Plan:
- LDR R3 in EX (ex_valid=1, ex_mem_read=1, ex_load_regfile=1, ex_dest=3), ID uses sr1=3 -> front_stall=1, back_stall=0, id_ex_bubble=1 for exactly 1 cycle. Next cycle ex_valid=0 -> all 0.
- Same load with id_uses_sr2=0 and id_sr2_reg=3 (imm_mode) -> no stall, no bubble.
- dmem_req=1, dmem_resp at cycle 5 -> front_stall=back_stall=1 for cycles 0-4, 0 at cycle 5. State returns to RUN at cycle 6.
- dmem busy 4 cycles, imem_resp at cycle 1 -> fetch_latch_en=1 at cycle 1 only, imem_read_mask=1 cycles 2-4, 0 after stall release.
- load_use and dmem_busy together for 3 cycles -> id_ex_bubble=0 during the wait, then exactly one bubble cycle.
- MEM_TIMEOUT=8, dmem_req held with no resp -> err_timeout rises after 8 MEM_WAIT cycles and stays 1 until reset. Asserting reset mid-wait -> state RUN, err_timeout=0 asynchronously.
